spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  Receiving end of the 3-wire write-only serial link (SEN/SCLK/SDATA) driven by the SPI master controller.
//  Oversamples the link in the local clock domain and deserializes each frame into {address, data}.
//  Pushes valid frames into an internal FIFO for user readback and flags malformed frames and drops.
//  Used on the test/loopback side and in peripheral emulation; packs words like the master's FIFO word.
// PARAMETERS
//  ADDR_BITS    8   address field width; address is sent first.
//  DATA_BITS    16  data field width; data is sent after the address.
//  FIFO_DEPTH   8   receive FIFO entries; must be a power of 2.
//  SYNC_STAGES  2   synchronizer flops on SEN, SCLK and SDATA; minimum 2.
// PORTS
//  clock       in   1   main clock; all state is on its rising edge.
//  reset_n     in   1   asynchronous, active-low reset.
//  SEN         in   1   serial enable from master, active low; asynchronous to clock.
//  SCLK        in   1   serial clock from master; asynchronous to clock.
//  SDATA       in   1   serial data; captured on the SCLK rising edge.
//  fifo_rden   in   1   pop the head word; ignored when data_empty=1.
//  data_out    out  32  head word {zeros, data[DATA_BITS-1:0], addr[ADDR_BITS-1:0]}; show-ahead.
//  data_empty  out  1   FIFO empty.
//  data_full   out  1   FIFO full.
//  busy        out  1   frame in progress (synchronized SEN low).
//  frame_err   out  1   one-cycle pulse: frame discarded because its bit count != ADDR_BITS+DATA_BITS.
//  overflow    out  1   one-cycle pulse: valid frame dropped because the FIFO was full.
// BEHAVIOUR
//  Reset: FSM=IDLE, bit counter=0, shift register=0, FIFO pointers=0, synchronizers=1 (idle line).
//   Outputs at reset: busy=0, frame_err=0, overflow=0, data_empty=1, data_full=0, data_out=0.
//  Sync: SEN, SCLK and SDATA each pass through SYNC_STAGES flops so all three have equal delay.
//   The SCLK rising edge is detected as sync_sclk & ~sclk_d, one cycle wide.
//   SCLK high and low phases must each last >= 3 clock periods (master ratio >= 6); faster links are unsupported.
//  Frame: MSB first, ADDR_BITS address bits then DATA_BITS data bits; total N = ADDR_BITS+DATA_BITS.
//   Shift register width is N; shift left by one and insert sync_sdata on each detected SCLK rising edge.
//  FSM states IDLE, SHIFT, CHECK:
//   IDLE:  sync SEN == 0 -> clear counter and shifter; go to SHIFT. busy=1 from this cycle.
//   SHIFT: on each SCLK rise, shift in and increment counter; counter saturates at N+1.
//          sync SEN == 1 -> go to CHECK; busy=0 from this cycle.
//   CHECK: (one cycle) if counter == N, push {addr,data} into the FIFO, else pulse frame_err; go to IDLE.
//          If counter == N and the FIFO is full without a same-cycle pop, pulse overflow and discard the word.
//   Latency: word visible on data_out and data_empty=0 two clock cycles after sync SEN rises.
//  Boundaries:
//   SCLK edges while SEN is high are ignored.
//   A SEN glitch low with no SCLK edges gives count 0 and pulses frame_err.
//   More than N edges saturate the counter and pulse frame_err; the frame is not pushed.
//   Push and pop in the same cycle when full: both happen; occupancy unchanged; no overflow.
//   Pop when empty: ignored; pointers unchanged.
//   Push and pop in the same cycle when empty: the word is written; data_out shows it next cycle.
//   Pointers wrap modulo FIFO_DEPTH. Occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
//   Reset mid-frame or mid-pop: everything returns to reset values; the partial frame is lost.
//   A new frame may start in the cycle after CHECK; back-to-back master frames are received loss-free.
// STRUCTURE
//  Shared package / header: FSM state localparams (IDLE/SHIFT/CHECK) and the frame packing
//   (address at [ADDR_BITS-1:0], data above it). Use the same definitions as the master controller.
//  One sub-module: spi_rx_fifo (DATA_SIZE=32, DEPTH=FIFO_DEPTH), show-ahead read, synchronous write,
//   and empty/full/occupancy outputs. Synchronizers, edge detect, shifter and FSM stay in the top level.
// TESTING
//  1 Loopback with the master (ratio 8): send addr 0xA5, data 0x1234 -> data_out=0x001234A5, data_empty 1->0.
//  2 Eight back-to-back frames with no pops -> data_full=1; a 9th frame -> overflow pulse, FIFO contents unchanged.
//     Eight pops -> values come out in order and data_empty=1.
//  3 Master model sends 23 SCLK edges, then 25 edges -> frame_err pulses twice; FIFO stays empty.
//  4 FIFO full; send a frame while fifo_rden=1 in the CHECK cycle -> no overflow; 8 entries; new word at the tail.
//  5 Assert reset_n=0 after 10 bits of a frame, then release -> all outputs at reset values.
//     The next full frame 0x3C/0xBEEF is received as 0x00BEEF3C.
//  6 Pulse SEN low for 4 clock cycles with no SCLK -> single frame_err pulse; busy high for those cycles only.

Source files
------------

// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the 3-wire serial receiver: FSM states and the
// {data, addr} word packing also used by the master controller's FIFO word.
package spi_slave_rx_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  // frame arrives address-first, so it sits as {addr, data}; the word swaps it to {data, addr}
  function automatic logic [WORD_W-1:0] pack_word(input logic [WORD_W-1:0] frame,
                                                  input int addr_bits,
                                                  input int data_bits);
    logic [WORD_W-1:0] mask, addr, data;
    mask = (WORD_W'(1) << data_bits) - WORD_W'(1);
    data = frame & mask;
    addr = frame >> data_bits;
    return (data << addr_bits) | addr;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead receive FIFO with occupancy count; DEPTH must be a power of 2 (>= 2).
module spi_rx_fifo #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [DATA_SIZE-1:0]         wr_data,
  input  logic                         rd_en,
  output logic [DATA_SIZE-1:0]         rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt;
  logic                 rd_ok, wr_ok;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;
  assign rd_ok = rd_en & ~empty;
  // a full FIFO still accepts a write when a pop frees the slot in the same cycle
  assign wr_ok = wr_en & (~full | rd_ok);

  // unwritten storage is never exposed: empty reads as zero
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spi_slave_rx.sv
// Receiver for the SEN/SCLK/SDATA write link: oversamples, deserializes each
// frame into {data, addr}, queues good frames and flags bad lengths and drops.
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                SEN,
  input  logic                SCLK,
  input  logic                SDATA,
  input  logic                fifo_rden,
  output logic [WORD_W-1:0]   data_out,
  output logic                data_empty,
  output logic                data_full,
  output logic                busy,
  output logic                frame_err,
  output logic                overflow
);

  localparam int N     = ADDR_BITS + DATA_BITS;
  localparam int CNT_W = $clog2(N + 2);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sen_sync, sclk_sync, sdata_sync;
  logic                   sclk_d;
  logic                   sync_sen, sync_sclk, sync_sdata, sclk_rise;

  rx_state_e              state, next_state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [N-1:0]           shreg;
  logic                   clear, shift_en, push;

  logic [WORD_W-1:0]      fifo_wdata;
  logic                   fifo_empty, fifo_full;
  logic [OCC_W-1:0]       fifo_count;

  // all three lines share one chain length so they stay aligned; idle line is high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sen_sync   <= '1;
      sclk_sync  <= '1;
      sdata_sync <= '1;
      sclk_d     <= 1'b1;
    end else begin
      sen_sync   <= {sen_sync[SYNC_STAGES-2:0], SEN};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], SDATA};
      sclk_d     <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sync_sen   = sen_sync[SYNC_STAGES-1];
  assign sync_sclk  = sclk_sync[SYNC_STAGES-1];
  assign sync_sdata = sdata_sync[SYNC_STAGES-1];
  assign sclk_rise  = sync_sclk & ~sclk_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    clear      = 1'b0;
    shift_en   = 1'b0;
    push       = 1'b0;
    frame_err  = 1'b0;
    overflow   = 1'b0;
    case (state)
      IDLE: begin
        if (!sync_sen) begin
          busy       = 1'b1;
          clear      = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (sync_sen) begin
          next_state = CHECK;
        end else begin
          busy     = 1'b1;
          shift_en = sclk_rise;
        end
      end
      CHECK: begin
        next_state = IDLE;
        if (bit_cnt == CNT_W'(N)) begin
          // a pop in this same cycle makes room, so full alone is not an overflow
          if ((fifo_count == OCC_W'(FIFO_DEPTH)) && !(fifo_rden && !fifo_empty))
            overflow = 1'b1;
          else
            push = 1'b1;
        end else begin
          frame_err = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[N-2:0], sync_sdata};
      // saturating at N+1 keeps over-long frames distinguishable from good ones
      if (bit_cnt != CNT_W'(N + 1)) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign fifo_wdata = pack_word(WORD_W'(shreg), ADDR_BITS, DATA_BITS);

  spi_rx_fifo #(
    .DATA_SIZE (WORD_W),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rden),
    .rd_data (data_out),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign data_empty = fifo_empty;
  assign data_full  = fifo_full;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed + randomized bench for spi_slave_rx: a master model drives the link at
// ratio 8 and a queue-based model predicts FIFO contents, frame errors and drops.
module tb_spi_slave_rx;

  logic        clock, reset_n;
  logic        sen, sclk, sdata, rden;
  logic [31:0] data_out;
  logic        data_empty, data_full, busy, frame_err, overflow;

  int checks = 0;
  int errors = 0;

  int err_seen  = 0;
  int ovf_seen  = 0;
  int busy_seen = 0;

  logic [31:0] exp_q[$];
  int exp_err = 0;
  int exp_ovf = 0;

  spi_slave_rx dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .SEN        (sen),
    .SCLK       (sclk),
    .SDATA      (sdata),
    .fifo_rden  (rden),
    .data_out   (data_out),
    .data_empty (data_empty),
    .data_full  (data_full),
    .busy       (busy),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n) begin
      err_seen  += int'(frame_err);
      ovf_seen  += int'(overflow);
      busy_seen += int'(busy);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bits(input int nbits, input logic [31:0] bits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk  = 1'b0;
      sdata = bits[i];
      tick(4);
      sclk  = 1'b1;
      tick(4);
    end
  endtask

  // leaves SEN freshly raised; the word lands four edges later
  task automatic send_frame(input int nbits, input logic [31:0] bits);
    sen = 1'b0;
    tick(4);
    send_bits(nbits, bits);
    tick(2);
    sen = 1'b1;
  endtask

  function automatic logic [31:0] mkword(input logic [7:0] a, input logic [15:0] d);
    return {8'h00, d, a};
  endfunction

  task automatic model_frame(input int nbits, input logic [31:0] bits);
    if (nbits == 24) begin
      if (exp_q.size() < 8) exp_q.push_back(mkword(bits[23:16], bits[15:0]));
      else exp_ovf++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic frame(input int nbits, input logic [31:0] bits);
    send_frame(nbits, bits);
    model_frame(nbits, bits);
    tick(6);
  endtask

  task automatic do_pop(input string tag);
    chk({tag, "_empty"}, 32'(data_empty), 32'(exp_q.size() == 0));
    if (exp_q.size() > 0) begin
      chk({tag, "_data"}, data_out, exp_q[0]);
      void'(exp_q.pop_front());
    end
    rden = 1'b1;
    tick(1);
    rden = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_err"}, 32'(err_seen), 32'(exp_err));
    chk({tag, "_ovf"}, 32'(ovf_seen), 32'(exp_ovf));
  endtask

  function automatic logic [31:0] rnd_frame();
    return {8'h00, 8'($urandom), 16'($urandom)};
  endfunction

  initial begin
    logic [31:0] bits;
    int          b0, nb;
    reset_n = 1'b0;
    sen = 1'b1; sclk = 1'b1; sdata = 1'b0; rden = 1'b0;
    tick(3);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_ferr",  32'(frame_err),  32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    chk("rst_empty", 32'(data_empty), 32'd1);
    chk("rst_full",  32'(data_full),  32'd0);
    chk("rst_dout",  data_out,        32'd0);
    reset_n = 1'b1;
    tick(2);

    // basic frame and its latency after SEN rises
    send_frame(24, 32'h00A51234);
    model_frame(24, 32'h00A51234);
    tick(3);
    chk("t1_empty_early", 32'(data_empty), 32'd1);
    tick(1);
    chk("t1_empty_late", 32'(data_empty), 32'd0);
    chk("t1_dout", data_out, 32'h001234A5);
    tick(2);
    chk_counts("t1");
    do_pop("t1_pop");

    // fill, overflow, drain in order
    for (int i = 0; i < 8; i++) frame(24, rnd_frame());
    chk("t2_full", 32'(data_full), 32'd1);
    frame(24, rnd_frame());
    chk_counts("t2");
    chk("t2_head", data_out, exp_q[0]);
    for (int i = 0; i < 8; i++) do_pop("t2_pop");
    chk("t2_empty", 32'(data_empty), 32'd1);
    do_pop("t2_pop_when_empty");

    // wrong lengths: short and saturating long
    frame(23, rnd_frame());
    frame(25, {7'h0, 25'($urandom)});
    chk_counts("t3");
    chk("t3_empty", 32'(data_empty), 32'd1);

    // full FIFO, pop coincides with the push cycle
    for (int i = 0; i < 8; i++) frame(24, rnd_frame());
    bits = rnd_frame();
    send_frame(24, bits);
    tick(3);
    chk("t4_head", data_out, exp_q[0]);
    void'(exp_q.pop_front());
    rden = 1'b1;
    tick(1);
    rden = 1'b0;
    model_frame(24, bits);
    tick(4);
    chk_counts("t4");
    chk("t4_full", 32'(data_full), 32'd1);
    chk("t4_tail", exp_q[7], mkword(bits[23:16], bits[15:0]));
    for (int i = 0; i < 8; i++) do_pop("t4_pop");

    // reset in the middle of a frame
    frame(24, rnd_frame());
    sen = 1'b0;
    tick(4);
    send_bits(10, 32'($urandom));
    reset_n = 1'b0;
    exp_q.delete();
    tick(2);
    chk("t5_busy",  32'(busy),       32'd0);
    chk("t5_empty", 32'(data_empty), 32'd1);
    chk("t5_full",  32'(data_full),  32'd0);
    chk("t5_dout",  data_out,        32'd0);
    sen = 1'b1; sclk = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    frame(24, 32'h003CBEEF);
    chk("t5_dout_after", data_out, 32'h00BEEF3C);
    chk_counts("t5");
    do_pop("t5_pop");

    // SEN glitch without SCLK
    b0 = busy_seen;
    sen = 1'b0;
    tick(4);
    sen = 1'b1;
    exp_err++;
    tick(6);
    chk("t6_busy_cycles", 32'(busy_seen - b0), 32'd4);
    chk_counts("t6");

    // randomized mix of lengths and pops
    for (int i = 0; i < 14; i++) begin
      nb = 23 + int'($urandom_range(0, 4));
      if (nb > 25) nb = 24;
      frame(nb, {7'h0, 25'($urandom)} & ((nb == 25) ? 32'h01FF_FFFF : 32'h00FF_FFFF));
      repeat ($urandom_range(0, 1)) do_pop("rnd_pop");
    end
    chk_counts("rnd");
    while (exp_q.size() > 0) do_pop("rnd_drain");
    chk("rnd_empty", 32'(data_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
